// File: rtl/uart_cmd_pkg.sv
// Shared types and byte constants for the UART host command controller.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_LEN,
        ST_GET_DATA,
        ST_WR_MEM,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_SEND,
        ST_WAIT_TX
    } state_e;

    localparam logic [7:0] OP_PING  = 8'h50;
    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter; expired is raised once the count reaches TIMEOUT_CYCLES-1.
module uart_cmd_timeout #(
    parameter  int TIMEOUT_CYCLES = 100000,
    localparam int CNT_W          = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = load_val;
        end else if (en && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Host command controller: parses P/W/R packets from UART RX, drives the memory
// port and returns replies through UART TX.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_done,
    input  logic                  rx_parity_error,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_en,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_we,
    output logic                  mem_re,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cmd_active,
    output logic                  rx_dropped
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  rd_q, rd_d;
    logic                  in_get, accepting, expired;
    logic [DATA_WIDTH-1:0] idx_inc;

    assign in_get     = state_q inside {ST_GET_ADDR, ST_GET_LEN, ST_GET_DATA};
    assign accepting  = in_get || (state_q == ST_IDLE);
    assign idx_inc    = idx_q + DATA_WIDTH'(1);
    assign mem_addr   = base_q + ADDR_WIDTH'(idx_q);
    assign mem_wdata  = wdata_q;
    assign tx_data    = txd_q;
    assign cmd_active = (state_q != ST_IDLE);

    uart_cmd_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (rx_done || !in_get),
        .load     (1'b0),
        .load_val ('0),
        .en       (in_get),
        .expired  (expired)
    );

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        txd_d      = txd_q;
        rd_d       = rd_q;
        tx_en      = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        rx_dropped = rx_done && !accepting;

        case (state_q)
            ST_IDLE: begin
                if (rx_done) begin
                    idx_d = '0;
                    rd_d  = 1'b0;
                    if (rx_data == DATA_WIDTH'(OP_PING)) begin
                        state_d = ST_SEND;
                        txd_d   = DATA_WIDTH'(OP_PING);
                    end else if (rx_data == DATA_WIDTH'(OP_WRITE)) begin
                        state_d = ST_GET_ADDR;
                    end else if (rx_data == DATA_WIDTH'(OP_READ)) begin
                        state_d = ST_GET_ADDR;
                        rd_d    = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        txd_d   = DATA_WIDTH'(NAK);
                    end
                end
            end
            ST_GET_ADDR: begin
                if (rx_done) begin
                    base_d  = ADDR_WIDTH'(rx_data);
                    state_d = ST_GET_LEN;
                end
            end
            ST_GET_LEN: begin
                if (rx_done) begin
                    len_d = rx_data;
                    if (rx_data == '0) begin
                        // Zero-length read has nothing to return; zero-length write still acks.
                        state_d = rd_q ? ST_IDLE : ST_SEND;
                        txd_d   = DATA_WIDTH'(ACK);
                        rd_d    = 1'b0;
                    end else begin
                        state_d = rd_q ? ST_RD_REQ : ST_GET_DATA;
                    end
                end
            end
            ST_GET_DATA: begin
                if (rx_done) begin
                    wdata_d = rx_data;
                    state_d = ST_WR_MEM;
                end
            end
            ST_WR_MEM: begin
                mem_we = 1'b1;
                idx_d  = idx_inc;
                if (idx_inc == len_q) begin
                    state_d = ST_SEND;
                    txd_d   = DATA_WIDTH'(ACK);
                end else begin
                    state_d = ST_GET_DATA;
                end
            end
            ST_RD_REQ: begin
                mem_re  = 1'b1;
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                txd_d   = mem_rdata;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (!tx_busy) begin
                    tx_en   = 1'b1;
                    state_d = ST_WAIT_TX;
                end
            end
            ST_WAIT_TX: begin
                if (tx_done) begin
                    if (rd_q && idx_inc != len_q) begin
                        idx_d   = idx_inc;
                        state_d = ST_RD_REQ;
                    end else begin
                        rd_d    = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A corrupt byte anywhere in the header/payload aborts the packet with NAK.
        if (rx_done && rx_parity_error && accepting) begin
            state_d = ST_SEND;
            txd_d   = DATA_WIDTH'(NAK);
            rd_d    = 1'b0;
        end else if (in_get && expired && !rx_done) begin
            state_d = ST_IDLE;
            rd_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            txd_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            txd_q   <= txd_d;
            rd_q    <= rd_d;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Packet-level bench: a byte-queue model predicts memory strobes and TX replies.
module tb_uart_cmd_ctrl;

    localparam int TO   = 20;
    localparam int BUSY = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_done = 1'b0;
    logic       rx_parity_error = 1'b0;
    logic       tx_busy = 1'b0;
    logic       tx_done = 1'b0;
    logic [7:0] mem_rdata = '0;
    logic [7:0] tx_data, mem_addr, mem_wdata;
    logic       tx_en, mem_we, mem_re, cmd_active, rx_dropped;

    uart_cmd_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_done(rx_done), .rx_parity_error(rx_parity_error),
        .tx_data(tx_data), .tx_en(tx_en), .tx_busy(tx_busy), .tx_done(tx_done),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .cmd_active(cmd_active), .rx_dropped(rx_dropped)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0, cyc = 0;
    logic [7:0] tb_mem    [256];
    logic [7:0] model_mem [256];
    logic [7:0] exp_wa[$], exp_wd[$], exp_ra[$], exp_tx[$], tx_log[$];
    int n_tx = 0, n_drop = 0, busy_cnt = 0;
    int last_rx = -1, first_re = -1, first_tx = -1, fall_cyc = -1, done_cyc = -1;
    logic prev_active = 1'b0;
    logic [7:0] tx_hold = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: check outputs at negedge, play UART TX / memory, release at posedge+1.
    task automatic step();
        logic s_en, s_we, s_re, s_act, s_drop;
        logic [7:0] s_txd, s_wd, s_a;
        @(negedge clk);
        cyc++;
        s_en = tx_en; s_we = mem_we; s_re = mem_re; s_act = cmd_active; s_drop = rx_dropped;
        s_txd = tx_data; s_wd = mem_wdata; s_a = mem_addr;
        if (!rst) begin
            chk("reset_outs", {s_act, s_en, s_txd, s_we, s_re, s_a, s_wd, s_drop}, 32'd0);
        end else begin
            if (rx_done) begin last_rx = cyc; first_re = -1; first_tx = -1; end
            if (s_drop) n_drop++;
            if (s_we || s_re) chk("we_re_exclusive", 32'(s_we & s_re), 32'd0);
            if (s_we) begin
                chk("we_expected", 32'(exp_wa.size() != 0), 32'd1);
                if (exp_wa.size() != 0) begin
                    chk("we_addr", s_a, exp_wa.pop_front());
                    chk("we_data", s_wd, exp_wd.pop_front());
                end
            end
            if (s_re) begin
                if (first_re < 0) first_re = cyc;
                chk("re_expected", 32'(exp_ra.size() != 0), 32'd1);
                if (exp_ra.size() != 0) chk("re_addr", s_a, exp_ra.pop_front());
            end
            if (s_en) begin
                if (first_tx < 0) first_tx = cyc;
                n_tx++;
                tx_log.push_back(s_txd);
                chk("tx_en_idle", 32'(tx_busy), 32'd0);
                chk("tx_expected", 32'(exp_tx.size() != 0), 32'd1);
                if (exp_tx.size() != 0) chk("tx_byte", s_txd, exp_tx.pop_front());
            end
            if (tx_busy && s_act) chk("tx_hold", s_txd, tx_hold);
            if (prev_active && !s_act) fall_cyc = cyc;
        end
        prev_active = s_act;
        tx_done = 1'b0;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) begin tx_busy = 1'b0; tx_done = 1'b1; done_cyc = cyc; end
        end
        if (s_we) tb_mem[s_a] = s_wd;
        if (s_re) mem_rdata = tb_mem[s_a];
        @(posedge clk);
        #1;
        if (s_en) begin tx_busy = 1'b1; busy_cnt = BUSY; tx_hold = s_txd; end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic perr);
        rx_data = b; rx_parity_error = perr; rx_done = 1'b1;
        step();
        rx_done = 1'b0; rx_parity_error = 1'b0;
        step(); step();
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while ((prev_active || tx_busy || exp_tx.size() != 0 || exp_ra.size() != 0 ||
                exp_wa.size() != 0) && k < 2000) begin
            step(); k++;
        end
        chk({"idle_", name}, 32'(k < 2000), 32'd1);
        step();
    endtask

    // bad >= 0: that payload byte carries a parity error and ends the packet.
    task automatic write_pkt(input logic [7:0] a, input int n, input logic [7:0] d [8], input int bad);
        logic [7:0] wa;
        for (int i = 0; i < n; i++) begin
            if (i == bad) break;
            wa = a + 8'(i);
            exp_wa.push_back(wa); exp_wd.push_back(d[i]); model_mem[wa] = d[i];
        end
        exp_tx.push_back(bad >= 0 ? 8'h15 : 8'h06);
        send_byte(8'h57, 1'b0); send_byte(a, 1'b0); send_byte(8'(n), 1'b0);
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], i == bad);
            if (i == bad) break;
        end
    endtask

    task automatic read_pkt(input logic [7:0] a, input int n);
        logic [7:0] ra;
        for (int i = 0; i < n; i++) begin
            ra = a + 8'(i);
            exp_ra.push_back(ra); exp_tx.push_back(model_mem[ra]);
        end
        send_byte(8'h52, 1'b0); send_byte(a, 1'b0); send_byte(8'(n), 1'b0);
    endtask

    initial begin
        logic [7:0] d [8];
        int base, k;
        for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; model_mem[i] = '0; end
        repeat (3) step();
        rst = 1'b1;
        step();

        // Ping
        exp_tx.push_back(8'h50);
        send_byte(8'h50, 1'b0);
        wait_idle("ping");
        chk("ping_latency", 32'(first_tx - last_rx), 32'd1);
        chk("ping_fall_after_done", 32'(fall_cyc - done_cyc), 32'd1);
        chk("ping_count", 32'(n_tx), 32'd1);
        chk("ping_byte", tx_log[$], 32'h50);

        // Write 3 bytes at 0x10, then read them back
        d = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_pkt(8'h10, 3, d, -1);
        wait_idle("write");
        chk("wr_ack", tx_log[$], 32'h06);
        chk("wr_mem10", tb_mem[8'h10], 32'hAA);
        chk("wr_mem12", tb_mem[8'h12], 32'hCC);
        read_pkt(8'h10, 3);
        wait_idle("read");
        chk("rd_re_latency", 32'(first_re - last_rx), 32'd1);
        chk("rd_tx_latency", 32'(first_tx - first_re), 32'd2);
        chk("rd_b0", tx_log[$-2], 32'hAA);
        chk("rd_b1", tx_log[$-1], 32'hBB);
        chk("rd_b2", tx_log[$], 32'hCC);

        // Address wrap
        d = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_pkt(8'hFF, 2, d, -1);
        wait_idle("wrap");
        chk("wrap_ff", tb_mem[8'hFF], 32'h11);
        chk("wrap_00", tb_mem[8'h00], 32'h22);
        chk("wrap_ack", tx_log[$], 32'h06);

        // Unknown opcode
        exp_tx.push_back(8'h15);
        send_byte(8'h33, 1'b0);
        wait_idle("badop");
        chk("badop_nak", tx_log[$], 32'h15);

        // Parity error on second payload byte
        d = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        write_pkt(8'h20, 2, d, 1);
        wait_idle("parity");
        chk("parity_mem20", tb_mem[8'h20], 32'h11);
        chk("parity_mem21", tb_mem[8'h21], 32'h00);
        chk("parity_nak", tx_log[$], 32'h15);

        // Timeout after a lone opcode, then a ping still works
        base = n_tx;
        send_byte(8'h57, 1'b0);
        wait_idle("timeout");
        chk("timeout_cycles", 32'(fall_cyc - last_rx), 32'(TO + 1));
        chk("timeout_no_tx", 32'(n_tx), 32'(base));
        exp_tx.push_back(8'h50);
        send_byte(8'h50, 1'b0);
        wait_idle("ping2");
        chk("ping2_byte", tx_log[$], 32'h50);

        // Byte arriving during a read reply is dropped
        read_pkt(8'h10, 3);
        send_byte(8'h77, 1'b0);
        wait_idle("drop");
        chk("drop_count", 32'(n_drop), 32'd1);
        chk("drop_b0", tx_log[$-2], 32'hAA);
        chk("drop_b2", tx_log[$], 32'hCC);

        // Reset during the second byte of a 4-byte read reply
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
        write_pkt(8'h30, 4, d, -1);
        wait_idle("wr4");
        exp_ra.push_back(8'h30); exp_ra.push_back(8'h31);
        exp_tx.push_back(model_mem[8'h30]); exp_tx.push_back(model_mem[8'h31]);
        base = n_tx;
        send_byte(8'h52, 1'b0); send_byte(8'h30, 1'b0); send_byte(8'h04, 1'b0);
        k = 0;
        while (n_tx < base + 2 && k < 500) begin step(); k++; end
        chk("rst_second_byte_seen", 32'(n_tx), 32'(base + 2));
        rst = 1'b0;
        #1;
        chk("async_reset_outs", {cmd_active, tx_en, tx_data, mem_we, mem_re, mem_addr,
                                 mem_wdata, rx_dropped}, 32'd0);
        repeat (3) step();
        rst = 1'b1;
        repeat (40) step();
        chk("no_tx_after_reset", 32'(n_tx), 32'(base + 2));
        chk("idle_after_reset", 32'(prev_active), 32'd0);
        chk("rst_bytes", {tx_log[$-1], tx_log[$]}, 32'h0102);

        chk("queues_empty", 32'(exp_wa.size() + exp_ra.size() + exp_tx.size()), 32'd0);
        chk("drop_total", 32'(n_drop), 32'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
